// File: rtl/lib_switch_allocator_rr.sv
// Separable switch allocator for a wormhole crossbar.
// Each output keeps its own IDLE/LOCKED state, an owner and a round-robin
// pointer. Grants are combinational from registered state, so a flit can be
// granted in the same cycle it requests. A non-tail grant locks the output
// to that input until its tail flit transfers.
module lib_switch_allocator_rr #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic [0:N-1][0:M-1]   i_req,
  input  logic [0:N-1]          i_tail,
  input  logic [0:M-1]          i_ready,
  output logic [0:M-1][0:N-1]   o_sel,
  output logic [0:N-1]          o_gnt
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Outputs are forced to zero while held in reset or with the clock disabled.
  logic                 w_en;
  logic [0:N-1]         w_valid;
  logic [0:M-1][0:N-1]  w_rq;

  assign w_en = ce & reset_n;

  // Next round-robin position after v, wrapping at N.
  function automatic logic [W-1:0] f_inc(input logic [W-1:0] v);
    return (v == W'(N - 1)) ? '0 : v + 1'b1;
  endfunction

  // A request counts only if it names exactly one output; anything else is
  // ignored so a corrupted header cannot grab several outputs at once.
  // w_rq is the transposed request matrix: w_rq[m][n] = input n wants m.
  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_in
      assign w_valid[gi] = (i_req[gi] != '0) &&
                           ((i_req[gi] & (i_req[gi] - 1'b1)) == '0);
      for (gj = 0; gj < M; gj++) begin : g_col
        assign w_rq[gj][gi] = w_valid[gi] & i_req[gi][gj];
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < M; gi++) begin : g_out
      state_t          r_state, w_state_next;
      logic [W-1:0]    r_owner, w_owner_next;
      logic [W-1:0]    r_ptr, w_ptr_next;
      logic [0:N-1]    w_sel;
      logic            w_found;
      logic [W-1:0]    w_win;

      // Arbitration and next-state: rotating search from ptr when idle,
      // owner-only forwarding when locked.
      always_comb begin
        w_sel        = '0;
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_found      = 1'b0;
        w_win        = '0;
        case (r_state)
          ST_IDLE: begin
            if (i_ready[gi]) begin
              for (int k = 0; k < N; k++) begin
                int           idx;
                logic [W-1:0] cand;
                idx = int'(r_ptr) + k;
                if (idx >= N) idx = idx - N;
                cand = W'(idx);
                if (!w_found && w_rq[gi][cand]) begin
                  w_found = 1'b1;
                  w_win   = cand;
                end
              end
              if (w_found) begin
                w_sel[w_win] = 1'b1;
                if (i_tail[w_win]) begin
                  w_ptr_next = f_inc(w_win);
                end else begin
                  w_state_next = ST_LOCKED;
                  w_owner_next = w_win;
                end
              end
            end
          end
          ST_LOCKED: begin
            // Stalls (owner not requesting or output busy) keep the lock.
            if (w_rq[gi][r_owner] && i_ready[gi]) begin
              w_sel[r_owner] = 1'b1;
              if (i_tail[r_owner]) begin
                w_state_next = ST_IDLE;
                w_ptr_next   = f_inc(r_owner);
              end
            end
          end
          default: begin
            w_state_next = ST_IDLE;
          end
        endcase
      end

      // State register: reset drops any lock and restarts arbitration at 0.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= ST_IDLE;
          r_owner <= '0;
          r_ptr   <= '0;
        end else if (ce) begin
          r_state <= w_state_next;
          r_owner <= w_owner_next;
          r_ptr   <= w_ptr_next;
        end
      end

      assign o_sel[gi] = w_en ? w_sel : '0;
    end
  endgenerate

  // An input transfers when any output selects it.
  always_comb begin
    o_gnt = '0;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) begin
        o_gnt[n] = o_gnt[n] | o_sel[m][n];
      end
    end
  end

endmodule

// File: tb/tb_lib_switch_allocator_rr.sv
// Bench for lib_switch_allocator_rr (N=M=4): directed per-cycle vectors with
// hand-computed expected selects, checked by a queue-based monitor.
module tb_lib_switch_allocator_rr;

  typedef logic [0:3][0:3] mat_t;

  typedef struct {
    string      name;
    mat_t       sel;
    logic [0:3] gnt;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        ce;
  mat_t        i_req;
  logic [0:3]  i_tail;
  logic [0:3]  i_ready;
  mat_t        o_sel;
  logic [0:3]  o_gnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  lib_switch_allocator_rr #(.N(4), .M(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .i_req   (i_req),
    .i_tail  (i_tail),
    .i_ready (i_ready),
    .o_sel   (o_sel),
    .o_gnt   (o_gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // response expected for that cycle.
  task automatic step(input string nm, input logic rn, input logic c,
                      input mat_t req, input logic [0:3] tl,
                      input logic [0:3] rdy, input mat_t es,
                      input logic [0:3] eg);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rn;
    ce      = c;
    i_req   = req;
    i_tail  = tl;
    i_ready = rdy;
    e.name  = nm;
    e.sel   = es;
    e.gnt   = eg;
    sb.push_back(e);
  endtask

  // Monitor: on the falling edge, compare the DUT against the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        bit bad;
        bad = 1'b0;
        e = sb.pop_front();
        checks++;
        if (o_sel !== e.sel) begin
          errors++;
          bad = 1'b1;
          $display("FAIL %s: o_sel=%b expected %b", e.name, o_sel, e.sel);
        end
        checks++;
        if (o_gnt !== e.gnt) begin
          errors++;
          bad = 1'b1;
          $display("FAIL %s: o_gnt=%b expected %b", e.name, o_gnt, e.gnt);
        end
        if (!bad)
          $display("ok   %-14s o_sel=%b o_gnt=%b", e.name, o_sel, o_gnt);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    ce      = 1'b1;
    i_req   = '0;
    i_tail  = '0;
    i_ready = '0;

    // Reset: outputs zero even with requests present.
    step("reset", 1'b0, 1'b1, {4'b0010,4'b0010,4'b0010,4'b0000}, 4'b1111, 4'b1111,
         '0, 4'b0000);
    // Contention on output 2: grants rotate 0,1,2.
    step("cont_0", 1'b1, 1'b1, {4'b0010,4'b0010,4'b0010,4'b0000}, 4'b1111, 4'b1111,
         {4'b0000,4'b0000,4'b1000,4'b0000}, 4'b1000);
    step("cont_1", 1'b1, 1'b1, {4'b0010,4'b0010,4'b0010,4'b0000}, 4'b1111, 4'b1111,
         {4'b0000,4'b0000,4'b0100,4'b0000}, 4'b0100);
    step("cont_2", 1'b1, 1'b1, {4'b0010,4'b0010,4'b0010,4'b0000}, 4'b1111, 4'b1111,
         {4'b0000,4'b0000,4'b0010,4'b0000}, 4'b0010);
    // Lock: input 1 sends 3 flits to output 0 while input 3 waits.
    step("lock_f1", 1'b1, 1'b1, {4'b0000,4'b1000,4'b0000,4'b1000}, 4'b0001, 4'b1111,
         {4'b0100,4'b0000,4'b0000,4'b0000}, 4'b0100);
    step("lock_f2", 1'b1, 1'b1, {4'b0000,4'b1000,4'b0000,4'b1000}, 4'b0001, 4'b1111,
         {4'b0100,4'b0000,4'b0000,4'b0000}, 4'b0100);
    step("lock_f3", 1'b1, 1'b1, {4'b0000,4'b1000,4'b0000,4'b1000}, 4'b0101, 4'b1111,
         {4'b0100,4'b0000,4'b0000,4'b0000}, 4'b0100);
    // ptr[0]=2 now, so input 3 beats a fresh request from input 1.
    step("lock_next", 1'b1, 1'b1, {4'b0000,4'b1000,4'b0000,4'b1000}, 4'b0101, 4'b1111,
         {4'b0001,4'b0000,4'b0000,4'b0000}, 4'b0001);
    // Backpressure: input 2 locks output 1, which then stalls for 2 cycles.
    step("bp_head", 1'b1, 1'b1, {4'b0000,4'b0000,4'b0100,4'b0000}, 4'b0000, 4'b1111,
         {4'b0000,4'b0010,4'b0000,4'b0000}, 4'b0010);
    step("bp_stall1", 1'b1, 1'b1, {4'b0100,4'b0000,4'b0100,4'b0000}, 4'b1000, 4'b1011,
         '0, 4'b0000);
    step("bp_stall2", 1'b1, 1'b1, {4'b0100,4'b0000,4'b0100,4'b0000}, 4'b1000, 4'b1011,
         '0, 4'b0000);
    step("bp_resume", 1'b1, 1'b1, {4'b0100,4'b0000,4'b0100,4'b0000}, 4'b1010, 4'b1111,
         {4'b0000,4'b0010,4'b0000,4'b0000}, 4'b0010);
    step("bp_after", 1'b1, 1'b1, {4'b0100,4'b0000,4'b0000,4'b0000}, 4'b1000, 4'b1111,
         {4'b0000,4'b1000,4'b0000,4'b0000}, 4'b1000);
    // Wrap/parallel: move ptr[3] to 3, then two outputs granted together.
    step("wrap_setup", 1'b1, 1'b1, {4'b0000,4'b0000,4'b0001,4'b0000}, 4'b0010, 4'b1111,
         {4'b0000,4'b0000,4'b0000,4'b0010}, 4'b0010);
    step("wrap_par", 1'b1, 1'b1, {4'b0001,4'b0000,4'b0100,4'b0001}, 4'b1111, 4'b1111,
         {4'b0000,4'b0010,4'b0000,4'b0001}, 4'b0011);
    step("wrap_next", 1'b1, 1'b1, {4'b0001,4'b0000,4'b0000,4'b0001}, 4'b1111, 4'b1111,
         {4'b0000,4'b0000,4'b0000,4'b1000}, 4'b1000);
    // Illegal multi-hot request is never granted.
    step("illegal", 1'b1, 1'b1, {4'b1100,4'b0000,4'b0000,4'b0000}, 4'b1111, 4'b1111,
         '0, 4'b0000);
    step("illegal_mix", 1'b1, 1'b1, {4'b1100,4'b0010,4'b0000,4'b0000}, 4'b1111, 4'b1111,
         {4'b0000,4'b0000,4'b0100,4'b0000}, 4'b0100);
    // Clock enable low: outputs zero, then the same requests proceed.
    step("ce_off", 1'b1, 1'b0, {4'b0000,4'b1000,4'b0010,4'b0000}, 4'b0010, 4'b1111,
         '0, 4'b0000);
    step("ce_on", 1'b1, 1'b1, {4'b0000,4'b1000,4'b0010,4'b0000}, 4'b0010, 4'b1111,
         {4'b0100,4'b0000,4'b0010,4'b0000}, 4'b0110);
    step("lock_hold", 1'b1, 1'b1, {4'b0000,4'b1000,4'b1000,4'b0000}, 4'b0010, 4'b1111,
         {4'b0100,4'b0000,4'b0000,4'b0000}, 4'b0100);
    // Reset mid-packet: outputs drop immediately, arbitration restarts at 0.
    step("rst_mid", 1'b0, 1'b1, {4'b0000,4'b1000,4'b1000,4'b0000}, 4'b0010, 4'b1111,
         '0, 4'b0000);
    step("rst_rel", 1'b1, 1'b1, {4'b1000,4'b0000,4'b1000,4'b0000}, 4'b1010, 4'b1111,
         {4'b1000,4'b0000,4'b0000,4'b0000}, 4'b1000);
    step("rst_next", 1'b1, 1'b1, {4'b1000,4'b0000,4'b1000,4'b0000}, 4'b1010, 4'b1111,
         {4'b0010,4'b0000,4'b0000,4'b0000}, 4'b0010);

    // Give the monitor a bounded number of cycles to drain the queue.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
